// File: rtl/f_fetch_if.sv
// Fetch-unit bus: D-stage redirect inputs, instruction memory, F/D register.
// F_addr_err exists only when FETCH_ADDR_CHECK_EN is defined.
interface f_fetch_if #(
  parameter int AW = 12
);
  logic          stall;
  logic          D_branch_ok;
  logic [1:0]    D_jump_type;
  logic [15:0]   D_imm16;
  logic [25:0]   D_instr_index;
  logic [31:0]   D_rs_data;
  logic [31:0]   imem_rdata;
  logic [AW-1:0] imem_addr;
  logic [31:0]   F_pc;
  logic [31:0]   D_instr;
  logic [31:0]   D_pc;
  logic [31:0]   D_pc8;
  logic          D_valid;
`ifdef FETCH_ADDR_CHECK_EN
  logic          F_addr_err;
`endif

  modport master (
    input  stall,
    input  D_branch_ok,
    input  D_jump_type,
    input  D_imm16,
    input  D_instr_index,
    input  D_rs_data,
    input  imem_rdata,
    output imem_addr,
    output F_pc,
    output D_instr,
    output D_pc,
    output D_pc8,
`ifdef FETCH_ADDR_CHECK_EN
    output F_addr_err,
`endif
    output D_valid
  );

  modport slave (
    output stall,
    output D_branch_ok,
    output D_jump_type,
    output D_imm16,
    output D_instr_index,
    output D_rs_data,
    output imem_rdata,
    input  imem_addr,
    input  F_pc,
    input  D_instr,
    input  D_pc,
    input  D_pc8,
`ifdef FETCH_ADDR_CHECK_EN
    input  F_addr_err,
`endif
    input  D_valid
  );
endinterface

// File: rtl/f_fetch_unit.sv
// Fetch PC and F/D pipeline register with delayed-branch redirect.
// Optional fetch address check: define FETCH_ADDR_CHECK_EN.
module f_fetch_unit #(
  parameter logic [31:0] PC_RESET       = 32'h0000_3000,
  parameter logic [31:0] IM_BASE        = 32'h0000_3000,
  parameter int          IM_DEPTH_WORDS = 4096
) (
  input  logic      clk,
  input  logic      reset,
  f_fetch_if.master bus
);
  localparam int AW = $clog2(IM_DEPTH_WORDS);

  logic [31:0] f_pc;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic        d_valid;
  logic [31:0] npc;
  logic [31:0] br_tgt;

  assign br_tgt = d_pc + 32'd4 +
    {{14{bus.D_imm16[15]}}, bus.D_imm16, 2'b00};

  // Next-PC select; redirects only come from a real instruction in D
  always_comb begin
    npc = f_pc + 32'd4;
    if (d_valid) begin
      unique case (bus.D_jump_type)
        2'b10: npc = bus.D_rs_data;
        2'b01: npc = {d_pc[31:28], bus.D_instr_index, 2'b00};
        2'b00: if (bus.D_branch_ok) npc = br_tgt;
        default: ;
      endcase
    end
  end

  assign bus.imem_addr = AW'((f_pc - IM_BASE) >> 2);
  assign bus.F_pc      = f_pc;
  assign bus.D_instr   = d_instr;
  assign bus.D_pc      = d_pc;
  assign bus.D_pc8     = d_pc + 32'd8;
  assign bus.D_valid   = d_valid;

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [32:0] IM_END =
    {1'b0, IM_BASE} + 33'(4 * IM_DEPTH_WORDS);

  logic fetch_ok;
  logic addr_err;

  assign fetch_ok = (f_pc[1:0] == 2'b00) && (f_pc >= IM_BASE) &&
                    ({1'b0, f_pc} < IM_END);
  assign bus.F_addr_err = addr_err;

  // Sticky error flag, set by the first bad fetch that advances
  always_ff @(posedge clk) begin
    if (reset) addr_err <= 1'b0;
    else if (!bus.stall && !fetch_ok) addr_err <= 1'b1;
  end
`endif

  // PC and F/D register; stall freezes both, reset wins over all
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc    <= PC_RESET;
      d_instr <= 32'h0;
      d_pc    <= 32'h0;
      d_valid <= 1'b0;
    end else if (!bus.stall) begin
      f_pc <= npc;
      d_pc <= f_pc;
`ifdef FETCH_ADDR_CHECK_EN
      d_instr <= fetch_ok ? bus.imem_rdata : 32'h0;
      d_valid <= fetch_ok;
`else
      d_instr <= bus.imem_rdata;
      d_valid <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_f_fetch_unit.sv
// Bench for f_fetch_unit: directed vector table then random run
// against a behavioural fetch model.
module tb_f_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  f_fetch_if #(.AW(12)) bus();

  f_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [11:0] a);
    return {16'hC0DE, 4'h0, a};
  endfunction

  always_comb bus.imem_rdata = mem_word(bus.imem_addr);

  function automatic logic [11:0] ix(logic [31:0] pc);
    logic [31:0] o;
    o = (pc - 32'h3000) >> 2;
    return o[11:0];
  endfunction

  function automatic logic ok(logic [31:0] pc);
`ifdef FETCH_ADDR_CHECK_EN
    return pc[1:0] == 2'b00 && pc >= 32'h3000 && pc < 32'h7000;
`else
    return pc == pc || 1'b1;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic [1:0]  jt;
    logic        bok;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic [31:0] fpc;
    logic [31:0] dpc;
    logic        dv;
  } vec_t;

  vec_t tv[19];

  task automatic drive(logic r, logic s, logic [1:0] jt, logic bok,
                       logic [15:0] imm, logic [25:0] idx,
                       logic [31:0] rs);
    reset             = r;
    bus.stall         = s;
    bus.D_jump_type   = jt;
    bus.D_branch_ok   = bok;
    bus.D_imm16       = imm;
    bus.D_instr_index = idx;
    bus.D_rs_data     = rs;
  endtask

  task automatic chk_all(string tag, logic [31:0] fpc,
                         logic [31:0] dpc, logic [31:0] di,
                         logic dv, logic err);
    chk({tag, " F_pc"}, bus.F_pc, fpc);
    chk({tag, " D_pc"}, bus.D_pc, dpc);
    chk({tag, " D_pc8"}, bus.D_pc8, dpc + 32'd8);
    chk({tag, " D_instr"}, bus.D_instr, di);
    chk({tag, " D_valid"}, 32'(bus.D_valid), 32'(dv));
    chk({tag, " imem_addr"}, 32'(bus.imem_addr), 32'(ix(fpc)));
`ifdef FETCH_ADDR_CHECK_EN
    chk({tag, " F_addr_err"}, 32'(bus.F_addr_err), 32'(err));
`else
    if (err) chk({tag, " err model"}, 32'(err), 32'h0);
`endif
  endtask

  logic [31:0] pf, edi, mf, mdp, mdi, npc;
  logic        edv, eerr, mdv, merr, r, s, bok, fo;
  logic [1:0]  jt;
  logic [15:0] imm;
  logic [25:0] idx;
  logic [31:0] rs;

  initial begin
    tv[0]  = '{1, 0, 2'b00, 0, 16'h0,    26'h0,   32'h0,
               32'h3000, 32'h0, 0};
    tv[1]  = '{0, 0, 2'b00, 0, 16'h0,    26'h0,   32'h0,
               32'h3004, 32'h3000, 1};
    tv[2]  = '{0, 0, 2'b00, 0, 16'h0,    26'h0,   32'h0,
               32'h3008, 32'h3004, 1};
    tv[3]  = '{0, 0, 2'b00, 0, 16'h0,    26'h0,   32'h0,
               32'h300C, 32'h3008, 1};
    tv[4]  = '{0, 0, 2'b00, 0, 16'h0,    26'h0,   32'h0,
               32'h3010, 32'h300C, 1};
    tv[5]  = '{0, 0, 2'b00, 0, 16'h0,    26'h0,   32'h0,
               32'h3014, 32'h3010, 1};
    tv[6]  = '{0, 0, 2'b00, 1, 16'hFFFC, 26'h0,   32'h0,
               32'h3004, 32'h3014, 1};
    tv[7]  = '{0, 0, 2'b00, 0, 16'h0,    26'h0,   32'h0,
               32'h3008, 32'h3004, 1};
    tv[8]  = '{0, 0, 2'b10, 0, 16'h0,    26'h0,   32'h3020,
               32'h3020, 32'h3008, 1};
    tv[9]  = '{0, 0, 2'b00, 0, 16'h0,    26'h0,   32'h0,
               32'h3024, 32'h3020, 1};
    tv[10] = '{0, 0, 2'b01, 0, 16'h0,    26'hC10, 32'h0,
               32'h3040, 32'h3024, 1};
    tv[11] = '{0, 1, 2'b10, 0, 16'h0,    26'h0,   32'h3100,
               32'h3040, 32'h3024, 1};
    tv[12] = '{0, 1, 2'b10, 0, 16'h0,    26'h0,   32'h3100,
               32'h3040, 32'h3024, 1};
    tv[13] = '{0, 0, 2'b10, 0, 16'h0,    26'h0,   32'h3100,
               32'h3100, 32'h3040, 1};
    tv[14] = '{1, 1, 2'b10, 0, 16'h0,    26'h0,   32'h3100,
               32'h3000, 32'h0, 0};
    tv[15] = '{0, 0, 2'b10, 0, 16'h0,    26'h0,   32'h5000,
               32'h3004, 32'h3000, 1};
    tv[16] = '{0, 0, 2'b11, 1, 16'h0,    26'h0,   32'h5000,
               32'h3008, 32'h3004, 1};
    tv[17] = '{0, 0, 2'b10, 0, 16'h0,    26'h0,   32'hFFFF_FFFC,
               32'hFFFF_FFFC, 32'h3008, 1};
    tv[18] = '{0, 0, 2'b00, 0, 16'h0,    26'h0,   32'h0,
               32'h0, 32'hFFFF_FFFC, 1};

    pf   = 32'h0;
    edi  = 32'h0;
    edv  = 1'b0;
    eerr = 1'b0;
    for (int i = 0; i < 19; i++) begin
      drive(tv[i].rst, tv[i].stall, tv[i].jt, tv[i].bok,
            tv[i].imm, tv[i].idx, tv[i].rs);
      @(posedge clk);
      #1;
      if (tv[i].rst) begin
        edi  = 32'h0;
        eerr = 1'b0;
      end else if (!tv[i].stall) begin
        edi = ok(pf) ? mem_word(ix(pf)) : 32'h0;
        if (!ok(pf)) eerr = 1'b1;
      end
      edv = tv[i].dv && (tv[i].rst || tv[i].stall || ok(pf));
      chk_all($sformatf("vec%0d", i), tv[i].fpc, tv[i].dpc,
              edi, edv, eerr);
      pf = tv[i].fpc;
    end

    mf   = pf;
    mdp  = tv[18].dpc;
    mdi  = edi;
    mdv  = edv;
    merr = eerr;
    for (int c = 0; c < 400; c++) begin
      r   = ($urandom_range(0, 39) == 0);
      s   = ($urandom_range(0, 3) == 0);
      jt  = 2'($urandom_range(0, 3));
      bok = 1'($urandom_range(0, 1));
      imm = 16'($urandom_range(0, 15)) - 16'd8;
      idx = 26'h0C00 + 26'($urandom_range(0, 4095));
      rs  = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
      if ($urandom_range(0, 15) == 0) rs = $urandom;
      drive(r, s, jt, bok, imm, idx, rs);

      if (!mdv || jt == 2'b11) npc = mf + 32'd4;
      else if (jt == 2'b10) npc = rs;
      else if (jt == 2'b01) npc = {mdp[31:28], idx, 2'b00};
      else if (bok) npc = mdp + 32'd4 + 32'(signed'(imm)) * 4;
      else npc = mf + 32'd4;

      if (r) begin
        mf   = 32'h3000;
        mdp  = 32'h0;
        mdi  = 32'h0;
        mdv  = 1'b0;
        merr = 1'b0;
      end else if (!s) begin
        fo  = ok(mf);
        mdi = fo ? mem_word(ix(mf)) : 32'h0;
        mdv = fo;
        if (!fo) merr = 1'b1;
        mdp = mf;
        mf  = npc;
      end

      @(posedge clk);
      #1;
      chk_all($sformatf("rnd%0d", c), mf, mdp, mdi, mdv, merr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/f_fetch_unit.md
Name: f_fetch_unit

Overview:
- Fetch-stage program counter plus F/D pipeline register for the 5-stage MIPS core.
- Consumes the D-stage branch-compare result and the D-stage jump decode to form the next PC.
- Drives the instruction-memory address and registers the fetched word and its PC into D.
- Delayed-branch semantics: the instruction in F when a D-stage control transfer resolves is the delay slot and is never flushed.

Parameters:
- PC_RESET, 32'h0000_3000, F_pc value after reset.
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
- IM_DEPTH_WORDS, 4096, instruction-memory depth in words; used for the address index and range check.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; holds PC and F/D register.
- D_branch_ok  in  1  D-stage comparator result; 1 = branch taken.
- D_jump_type  in  2  00 branch/none, 01 j/jal, 10 jr/jalr, 11 reserved.
- D_imm16  in  16  branch offset field of the instruction in D.
- D_instr_index  in  26  j/jal target field of the instruction in D.
- D_rs_data  in  32  forwarded rs value for jr/jalr.
- imem_rdata  in  32  instruction word at imem_addr (combinational read).
- imem_addr  out  12  word index: (F_pc - IM_BASE) >> 2, low log2(IM_DEPTH_WORDS) bits.
- F_pc  out  32  current fetch PC.
- D_instr  out  32  registered instruction for D.
- D_pc  out  32  registered PC of D_instr.
- D_pc8  out  32  D_pc + 8, link value for jal/jalr.
- D_valid  out  1  1 = D holds a real fetched instruction.

Behaviour:
- Reset (clk edge with reset=1) values: F_pc=PC_RESET, D_instr=0, D_pc=0, D_valid=0, D_pc8=8 (D_pc8 is always D_pc+8).
- reset has priority over stall and over every redirect.
- Next-PC select, combinational, priority high to low:
  - D_valid=1 and D_jump_type=10: D_rs_data.
  - D_valid=1 and D_jump_type=01: {D_pc[31:28], D_instr_index, 2'b00}.
  - D_valid=1, D_jump_type=00, D_branch_ok=1: D_pc + 4 + (sign_extend(D_imm16) << 2).
  - Otherwise, including jump_type 11 and D_valid=0: F_pc + 4.
- Adds are 32-bit modulo 2^32. No overflow detection; 32'hFFFF_FFFC + 4 wraps to 0.
- stall=0 at clk edge: F_pc <= npc; D_instr <= imem_rdata; D_pc <= F_pc; D_valid <= 1.
- stall=1 at clk edge: F_pc, D_instr, D_pc, D_valid all hold.
  - A redirect presented while stalled is ignored that cycle. It is re-evaluated from the held D contents when stall drops.
- Redirect latency: a control transfer in D during cycle n puts the target in F_pc at cycle n+1. The delay slot (F at cycle n) enters D at cycle n+1, unflushed.
- jr target is used verbatim. Misaligned targets are not corrected (see optional feature).
- Control transfer in the delay slot is architecturally undefined. The block still applies the priority rules above without special casing.
- Reset mid-stall or mid-redirect: the PC_RESET state is applied on that edge and any pending redirect is discarded.

Optional Feature:
- Macro: FETCH_ADDR_CHECK_EN.
- When defined, a fetch is invalid if F_pc[1:0]!=0, F_pc < IM_BASE, or F_pc >= IM_BASE + 4*IM_DEPTH_WORDS.
  - On a non-stalled edge with an invalid fetch: D_instr <= 32'h0 (nop), D_valid <= 0. D_pc still gets F_pc.
  - Extra output F_addr_err (1 bit) is sticky; it is set on the first invalid fetch and cleared only by reset.
- When undefined: no check, no F_addr_err port, imem_rdata is always registered.

Test Plan:
- Reset then 3 free-running cycles -> F_pc 0x3000, 0x3004, 0x3008, 0x300C; D_pc trails F_pc by one cycle; D_valid=0 until the first non-reset edge.
- D_pc=0x3010, D_jump_type=00, D_branch_ok=1, D_imm16=0xFFFC -> next F_pc=0x3004; delay slot at 0x3014 enters D unflushed.
- D_pc=0x3020, jump_type=01, index=0x0000C10 -> next F_pc=0x3040 (0x0000C10 << 2); D_pc8=0x3028.
- jump_type=10, D_rs_data=0x3100, stall=1 for 2 cycles then 0 -> F_pc and D hold for 2 cycles, then F_pc=0x3100.
- F_pc=0xFFFF_FFFC, no redirect -> wraps to 0x0000_0000 (with FETCH_ADDR_CHECK_EN, F_addr_err=1 and D_instr=0).
- reset asserted while stall=1 and a jr in D -> next edge F_pc=0x3000, D_valid=0, D_instr=0.
